// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
//   FIFO_MODE_STD  : registered read, rdata/rvalid one cycle after an accepted read
//   FIFO_MODE_FWFT : first-word-fall-through, head entry visible on rdata
//   clog2()        : ceiling log2, usable in constant expressions
package fifo_pkg;

   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for sync_fifo_flags: synchronous write, combinational read, no reset.
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data (combinational from raddr_i)
module fifo_mem #(
   parameter int DSIZE = 11,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [DSIZE-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [DSIZE-1:0] rdata_o
);

   logic [DSIZE-1:0] mem_q [2**AW];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with selectable read mode, almost flags, occupancy count,
// synchronous flush and sticky overflow/underflow.
//   clk, rst        clock, asynchronous active-high reset
//   flush           synchronous clear of pointers, rvalid and error flags
//   valid, wreq     write gate and write request
//   wdata           write data
//   rreq            read request (pop in FWFT mode)
//   rdata, rvalid   read data and qualifier
//   wfull, rempty   count == DEPTH / count == 0
//   almost_full     count >= AFULL_THRESH
//   almost_empty    count <= AEMPTY_THRESH
//   count           occupancy 0..DEPTH
//   overflow        sticky: a write was dropped
//   underflow       sticky: a read was rejected
module sync_fifo_flags
   import fifo_pkg::*;
#(
   parameter int DSIZE         = 11,
   parameter int ASIZE         = 4,
   parameter int FWFT          = 0,
   parameter int AFULL_THRESH  = 2**ASIZE - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             valid,
   input  logic             wreq,
   input  logic [DSIZE-1:0] wdata,
   input  logic             rreq,
   output logic [DSIZE-1:0] rdata,
   output logic             rvalid,
   output logic             wfull,
   output logic             rempty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [ASIZE:0]   count,
   output logic             overflow,
   output logic             underflow
);

   localparam int DEPTH = 2**ASIZE;
   localparam int AW    = clog2(DEPTH);
   localparam int CW    = ASIZE + 1;

   localparam logic [ASIZE:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [ASIZE:0] AFULL_C  = CW'(AFULL_THRESH);
   localparam logic [ASIZE:0] AEMPTY_C = CW'(AEMPTY_THRESH);

   if (AFULL_THRESH > DEPTH || AEMPTY_THRESH >= DEPTH) begin : g_bad_thresh
      $error("sync_fifo_flags: AFULL_THRESH must be <= DEPTH and AEMPTY_THRESH < DEPTH");
   end

   logic [ASIZE:0]   wptr_q, wptr_d;
   logic [ASIZE:0]   rptr_q, rptr_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [ASIZE:0]   count_w;
   logic             full_w, empty_w;
   logic             wa, ra;
   logic [DSIZE-1:0] mem_rdata;

   // Extra pointer MSB makes the difference span 0..DEPTH, so occupancy
   // comes straight from the registered pointers.
   assign count_w = wptr_q - rptr_q;
   assign full_w  = (count_w == DEPTH_C);
   assign empty_w = (count_w == '0);

   assign ra = rreq & ~empty_w;
   // A read in the same cycle frees the slot, so a full FIFO still takes the write.
   assign wa = valid & wreq & (~full_w | ra);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      ovf_d  = ovf_q | (valid & wreq & ~wa);
      unf_d  = unf_q | (rreq & ~ra);
      if (wa) wptr_d = wptr_q + 1'b1;
      if (ra) rptr_d = rptr_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else if (flush) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
      end
   end

   fifo_mem #(
      .DSIZE (DSIZE),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .we_i    (wa & ~flush),
      .waddr_i (wptr_q[AW-1:0]),
      .wdata_i (wdata),
      .raddr_i (rptr_q[AW-1:0]),
      .rdata_o (mem_rdata)
   );

   if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Memory has no reset; masking while empty keeps rdata at 0 after reset/flush.
      assign rdata  = empty_w ? '0 : mem_rdata;
      assign rvalid = ~empty_w;
   end else begin : g_std
      logic [DSIZE-1:0] rdata_q;
      logic             rvalid_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
         end else if (flush) begin
            rvalid_q <= 1'b0;
         end else begin
            rvalid_q <= ra;
            if (ra) rdata_q <= mem_rdata;
         end
      end

      assign rdata  = rdata_q;
      assign rvalid = rvalid_q;
   end

   assign count        = count_w;
   assign wfull        = full_w;
   assign rempty       = empty_w;
   assign almost_full  = (count_w >= AFULL_C);
   assign almost_empty = (count_w <= AEMPTY_C);
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: one registered-read and one FWFT instance share stimulus;
// a queue model predicts both and is compared every cycle, with literal spot checks.
module tb_sync_fifo_flags;

   localparam int DSIZE = 11;
   localparam int ASIZE = 4;
   localparam int DEPTH = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             valid = 1'b0;
   logic             wreq = 1'b0;
   logic             rreq = 1'b0;
   logic [DSIZE-1:0] wdata = '0;

   logic [DSIZE-1:0] s_rdata, f_rdata;
   logic             s_rvalid, f_rvalid;
   logic             s_wfull, f_wfull, s_rempty, f_rempty;
   logic             s_af, f_af, s_ae, f_ae;
   logic [ASIZE:0]   s_count, f_count;
   logic             s_ovf, f_ovf, s_unf, f_unf;

   int n_tests = 0;
   int n_fail  = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   sync_fifo_flags #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(0)) u_std (
      .clk(clk), .rst(rst), .flush(flush), .valid(valid), .wreq(wreq), .wdata(wdata),
      .rreq(rreq), .rdata(s_rdata), .rvalid(s_rvalid), .wfull(s_wfull), .rempty(s_rempty),
      .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
      .overflow(s_ovf), .underflow(s_unf)
   );

   sync_fifo_flags #(.DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .flush(flush), .valid(valid), .wreq(wreq), .wdata(wdata),
      .rreq(rreq), .rdata(f_rdata), .rvalid(f_rvalid), .wfull(f_wfull), .rempty(f_rempty),
      .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
      .overflow(f_ovf), .underflow(f_unf)
   );

   // Behavioural model: contents as a queue, flags from its size.
   int mq[$];
   int m_rd  = 0;
   bit m_rv  = 0;
   bit m_ovf = 0;
   bit m_unf = 0;

   always @(posedge clk or posedge rst) begin
      bit ra, wa;
      if (rst) begin
         mq.delete();
         m_rd = 0; m_rv = 0; m_ovf = 0; m_unf = 0;
      end else if (flush) begin
         mq.delete();
         m_rv = 0; m_ovf = 0; m_unf = 0;
      end else begin
         ra = rreq && (mq.size() > 0);
         wa = valid && wreq && ((mq.size() < DEPTH) || ra);
         if (rreq && !ra) m_unf = 1;
         if (valid && wreq && !wa) m_ovf = 1;
         m_rv = ra;
         if (ra) m_rd = mq.pop_front();
         if (wa) mq.push_back(int'(wdata));
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      int sz;
      sz = mq.size();
      chk("s_rdata",  int'(s_rdata), m_rd);
      chk("s_rvalid", int'(s_rvalid), int'(m_rv));
      chk("f_rvalid", int'(f_rvalid), (sz > 0) ? 1 : 0);
      chk("f_rdata",  int'(f_rdata), (sz > 0) ? mq[0] : 0);
      chk("s_count",  int'(s_count), sz);
      chk("f_count",  int'(f_count), sz);
      chk("s_wfull",  int'(s_wfull), (sz == DEPTH) ? 1 : 0);
      chk("f_wfull",  int'(f_wfull), (sz == DEPTH) ? 1 : 0);
      chk("s_rempty", int'(s_rempty), (sz == 0) ? 1 : 0);
      chk("f_rempty", int'(f_rempty), (sz == 0) ? 1 : 0);
      chk("s_afull",  int'(s_af), (sz >= DEPTH - 2) ? 1 : 0);
      chk("f_afull",  int'(f_af), (sz >= DEPTH - 2) ? 1 : 0);
      chk("s_aempty", int'(s_ae), (sz <= 2) ? 1 : 0);
      chk("f_aempty", int'(f_ae), (sz <= 2) ? 1 : 0);
      chk("s_ovf",    int'(s_ovf), int'(m_ovf));
      chk("f_ovf",    int'(f_ovf), int'(m_ovf));
      chk("s_unf",    int'(s_unf), int'(m_unf));
      chk("f_unf",    int'(f_unf), int'(m_unf));
   endtask

   always @(posedge clk) begin
      #1;
      if (started) compare_model();
   end

   // Inputs change at the falling edge and hold across exactly one rising edge.
   task automatic step(input bit v, input bit w, input int d, input bit r, input bit f);
      valid = v; wreq = w; wdata = DSIZE'(d); rreq = r; flush = f;
      @(negedge clk);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rdata"},  int'(s_rdata), 0);
      chk({tag, "_rvalid"}, int'(s_rvalid), 0);
      chk({tag, "_f_rdata"}, int'(f_rdata), 0);
      chk({tag, "_f_rvalid"}, int'(f_rvalid), 0);
      chk({tag, "_wfull"},  int'(s_wfull), 0);
      chk({tag, "_rempty"}, int'(s_rempty), 1);
      chk({tag, "_afull"},  int'(s_af), 0);
      chk({tag, "_aempty"}, int'(s_ae), 1);
      chk({tag, "_count"},  int'(s_count), 0);
      chk({tag, "_f_count"}, int'(f_count), 0);
      chk({tag, "_ovf"},    int'(s_ovf), 0);
      chk({tag, "_unf"},    int'(s_unf), 0);
   endtask

   initial begin
      #1;
      chk_reset_vals("por");
      @(negedge clk);
      rst = 1'b0;
      started = 1'b1;

      // Basic registered read
      for (int i = 1; i <= 3; i++) step(1, 1, i, 0, 0);
      chk("basic_count", int'(s_count), 3);
      for (int i = 1; i <= 3; i++) begin
         step(0, 0, 0, 1, 0);
         chk("basic_rdata", int'(s_rdata), i);
         chk("basic_rvalid", int'(s_rvalid), 1);
      end
      idle();
      chk("basic_rvalid_pulse", int'(s_rvalid), 0);
      chk("basic_rdata_hold", int'(s_rdata), 3);
      chk("basic_empty", int'(s_rempty), 1);

      // Valid gating
      for (int i = 0; i < 3; i++) step(0, 1, 7, 0, 0);
      chk("gate_count", int'(s_count), 0);
      chk("gate_ovf", int'(s_ovf), 0);
      step(1, 1, 7, 0, 0);
      chk("gate_count1", int'(s_count), 1);
      step(0, 0, 0, 1, 0);
      chk("gate_rdata", int'(s_rdata), 7);

      // FWFT visibility and pop
      step(1, 1, 5, 0, 0);
      chk("fwft_rvalid", int'(f_rvalid), 1);
      chk("fwft_rdata", int'(f_rdata), 5);
      step(0, 0, 0, 1, 0);
      chk("fwft_empty", int'(f_rempty), 1);
      chk("fwft_rvalid0", int'(f_rvalid), 0);

      // Fill to full, watch almost_full, overflow
      for (int i = 0; i < 16; i++) begin
         step(1, 1, i, 0, 0);
         chk("fill_afull", int'(s_af), (i + 1 >= 14) ? 1 : 0);
      end
      chk("full_wfull", int'(s_wfull), 1);
      step(1, 1, 99, 0, 0);
      chk("ovf_set", int'(s_ovf), 1);
      chk("ovf_count", int'(s_count), 16);
      // Simultaneous at full
      step(1, 1, 50, 1, 0);
      chk("sim_full_count", int'(s_count), 16);
      chk("sim_full_rdata", int'(s_rdata), 0);
      for (int i = 1; i <= 16; i++) begin
         step(0, 0, 0, 1, 0);
         chk("drain_rdata", int'(s_rdata), (i == 16) ? 50 : i);
      end
      chk("drain_empty", int'(s_rempty), 1);
      // Simultaneous at empty
      step(1, 1, 60, 1, 0);
      chk("sim_empty_count", int'(s_count), 1);
      chk("sim_empty_unf", int'(s_unf), 1);
      chk("sim_empty_rvalid", int'(s_rvalid), 0);
      step(0, 0, 0, 1, 0);
      chk("sim_empty_rdata", int'(s_rdata), 60);

      // Flush with a concurrent write
      for (int i = 0; i < 9; i++) step(1, 1, 300 + i, 0, 0);
      chk("pre_flush_count", int'(s_count), 9);
      step(1, 1, 123, 1, 1);
      chk("flush_count", int'(s_count), 0);
      chk("flush_empty", int'(f_rempty), 1);
      chk("flush_ovf", int'(s_ovf), 0);
      chk("flush_unf", int'(s_unf), 0);
      chk("flush_rvalid", int'(s_rvalid), 0);
      step(1, 1, 77, 0, 0);
      chk("post_flush_head", int'(f_rdata), 77);
      step(0, 0, 0, 1, 0);
      chk("post_flush_rdata", int'(s_rdata), 77);

      // Asynchronous reset between edges
      for (int i = 0; i < 3; i++) step(1, 1, 400 + i, 0, 0);
      step(0, 0, 0, 1, 0);
      chk("pre_rst_rvalid", int'(s_rvalid), 1);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_vals("arst");
      @(negedge clk);
      rst = 1'b0;

      // Pointer wrap: 40 write/read pairs
      for (int i = 0; i < 40; i++) begin
         step(1, 1, 500 + i, 0, 0);
         step(0, 0, 0, 1, 0);
         chk("wrap_rdata", int'(s_rdata), 500 + i);
      end
      idle();
      chk("wrap_empty", int'(s_rempty), 1);

      started = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
